// File: rtl/bit_serial_comparator_if.sv
// rtl/bit_serial_comparator_if.sv - serial operand link and result bundle for bit_serial_comparator
// master drives the operand stream, slave is the comparator.
interface bit_serial_comparator_if;
  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic busy;
  logic done;
  logic g;
  logic e;
  logic l;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  busy, done, g, e, l
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output busy, done, g, e, l
  );
endinterface

// File: rtl/bit_serial_comparator.sv
// rtl/bit_serial_comparator.sv - bit-serial unsigned magnitude comparator with registered g/e/l
// Define BIT_SERIAL_CMP_LSB_FIRST_EN for LSB-first operand order (default MSB first).
module bit_serial_comparator #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  bit_serial_comparator_if.slave  cmp_if
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gt_q, gt_d;
  logic          lt_q, lt_d;
  logic          g_q, e_q, l_q;
  logic          gt_fold, lt_fold;
  logic          load_res;

  // Running flags with the current bit pair folded in.
  always_comb begin
    gt_fold = gt_q;
    lt_fold = lt_q;
`ifdef BIT_SERIAL_CMP_LSB_FIRST_EN
    if (cmp_if.a_bit != cmp_if.b_bit) begin
      gt_fold = cmp_if.a_bit;
      lt_fold = cmp_if.b_bit;
    end
`else
    if (!gt_q && !lt_q) begin
      gt_fold = cmp_if.a_bit & ~cmp_if.b_bit;
      lt_fold = ~cmp_if.a_bit & cmp_if.b_bit;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    load_res = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        gt_d  = 1'b0;
        lt_d  = 1'b0;
        if (cmp_if.start) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (cmp_if.bit_valid) begin
          gt_d = gt_fold;
          lt_d = lt_fold;
          if (cnt_q == LAST_IDX) begin
            state_d  = REPORT;
            load_res = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  // Result is captured on the final-bit edge so it is visible alongside done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q <= 1'b0;
      e_q <= 1'b0;
      l_q <= 1'b0;
    end else if (load_res) begin
      g_q <= gt_d;
      e_q <= ~gt_d & ~lt_d;
      l_q <= lt_d;
    end
  end

  assign cmp_if.busy = (state_q == COLLECT);
  assign cmp_if.done = (state_q == REPORT);
  assign cmp_if.g    = g_q;
  assign cmp_if.e    = e_q;
  assign cmp_if.l    = l_q;

endmodule

// File: tb/tb_bit_serial_comparator.sv
// tb/tb_bit_serial_comparator.sv - scoreboard bench for bit_serial_comparator
// Honours BIT_SERIAL_CMP_LSB_FIRST_EN for operand shift order.
module tb_bit_serial_comparator;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_mis;

  typedef struct {
    logic [2:0] gel;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  bit_serial_comparator_if cmp_if ();

  bit_serial_comparator #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .cmp_if (cmp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && cmp_if.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("gel", {29'd0, cmp_if.g, cmp_if.e, cmp_if.l}, {29'd0, x.gel});
        chk("done_cycle", cyc, x.cyc);
        chk("busy_in_done", {31'd0, cmp_if.busy}, 32'd0);
      end
    end
  end

  function automatic int bit_idx(input int i);
`ifdef BIT_SERIAL_CMP_LSB_FIRST_EN
    return i;
`else
    return WIDTH - 1 - i;
`endif
  endfunction

  task automatic run_cmp(input logic [3:0] a, input logic [3:0] b, input logic [2:0] gel,
                         input int gap_after, input int gap_len,
                         input bit start_mid, input bit start_at_done);
    int s;
    @(negedge clk);
    cmp_if.start     = 1'b1;
    cmp_if.bit_valid = 1'b1;
    cmp_if.a_bit     = ~a[bit_idx(0)];
    cmp_if.b_bit     = ~b[bit_idx(0)];
    s = cyc + 1;
    sb.push_back('{gel: gel, cyc: s + WIDTH + gap_len});
    for (int i = 0; i < WIDTH; i++) begin
      if (i == gap_after) begin
        for (int k = 0; k < gap_len; k++) begin
          @(negedge clk);
          cmp_if.start     = start_mid;
          cmp_if.bit_valid = 1'b0;
          cmp_if.a_bit     = 1'b1;
          cmp_if.b_bit     = 1'b0;
        end
      end
      @(negedge clk);
      cmp_if.start     = start_mid && (i == 1);
      cmp_if.bit_valid = 1'b1;
      cmp_if.a_bit     = a[bit_idx(i)];
      cmp_if.b_bit     = b[bit_idx(i)];
      if (i == 0) chk("busy_after_start", {31'd0, cmp_if.busy}, 32'd1);
    end
    @(negedge clk);
    cmp_if.start     = start_at_done;
    cmp_if.bit_valid = 1'b0;
    @(negedge clk);
    cmp_if.start = 1'b0;
    chk("idle_after_done", {30'd0, cmp_if.busy, cmp_if.done}, 32'd0);
  endtask

  initial begin
    cyc = 0;
    n_vec = 0;
    n_mis = 0;
    rst = 1'b1;
    cmp_if.start     = 1'b0;
    cmp_if.bit_valid = 1'b0;
    cmp_if.a_bit     = 1'b0;
    cmp_if.b_bit     = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {27'd0, cmp_if.busy, cmp_if.done, cmp_if.g, cmp_if.e, cmp_if.l}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {27'd0, cmp_if.busy, cmp_if.done, cmp_if.g, cmp_if.e, cmp_if.l}, 32'd0);

    run_cmp(4'b0000, 4'b1000, 3'b001, 99, 0, 1'b0, 1'b0);
    run_cmp(4'b0000, 4'b0001, 3'b001, 99, 0, 1'b0, 1'b0);

    run_cmp(4'b1000, 4'b0000, 3'b100, 99, 0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("flags_hold", {29'd0, cmp_if.g, cmp_if.e, cmp_if.l}, 32'b100);
    end

    run_cmp(4'b1010, 4'b1010, 3'b010, 2, 3, 1'b0, 1'b0);

    run_cmp(4'b0110, 4'b0101, 3'b100, 99, 0, 1'b1, 1'b0);

    run_cmp(4'b0101, 4'b0110, 3'b001, 99, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("start_in_done_ignored", {31'd0, cmp_if.busy}, 32'd0);

    @(negedge clk);
    cmp_if.start     = 1'b1;
    cmp_if.bit_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmp_if.start     = 1'b0;
      cmp_if.bit_valid = 1'b1;
      cmp_if.a_bit     = 1'b1;
      cmp_if.b_bit     = 1'b0;
    end
    @(negedge clk);
    cmp_if.bit_valid = 1'b0;
    chk("busy_before_reset", {31'd0, cmp_if.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_outputs", {27'd0, cmp_if.busy, cmp_if.done, cmp_if.g, cmp_if.e, cmp_if.l}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_cmp(4'b0011, 4'b0011, 3'b010, 99, 0, 1'b0, 1'b0);

    run_cmp(4'b1000, 4'b0111, 3'b100, 99, 0, 1'b0, 1'b0);
    run_cmp(4'b0111, 4'b1000, 3'b001, 99, 0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
